commit_ctrl: RTL

//  In-order retirement sequencer between the ROB head and the renamed register file.
//  - Pops completed ROB entries and drives the regfile write-back port.
//  - Handshakes stores with the LSU before they retire.
//  - Drives the regfile rollback on a mispredict and broadcasts a pipeline flush.
//  - Owns the regfile enable/stall controls and protects x0 from writes.

---
 rtl/commit_ctrl.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/commit_ctrl.sv
// In-order retirement sequencer between the ROB head and the renamed register file.
// Optional: define COMMIT_CNT_EN to add a 64-bit retired-instruction counter output.
module commit_ctrl #(
  parameter int ROB_BIT   = 4,
  parameter int REG_BIT   = 5,
  parameter int FLUSH_CYC = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rdy,
  input  logic               id_stall,
  input  logic               rob_hd_vld,
  input  logic               rob_hd_done,
  input  logic [ROB_BIT-1:0] rob_hd_idx,
  input  logic               rob_hd_wb,
  input  logic [REG_BIT-1:0] rob_hd_rd,
  input  logic [31:0]        rob_hd_val,
  input  logic               rob_hd_store,
  input  logic               rob_hd_mispred,
  output logic               rob_pop,
  output logic               lsu_st_req,
  input  logic               lsu_st_ack,
  output logic               reg_en,
  output logic               reg_st,
  output logic               reg_rb,
  output logic               rob_wr_ena,
  output logic [REG_BIT-1:0] rob_wr_rd,
  output logic [31:0]        rob_wr_val,
  output logic [ROB_BIT-1:0] rob_wr_idx,
  output logic               flush
`ifdef COMMIT_CNT_EN
  ,
  output logic [63:0]        commit_cnt
`endif
);

  localparam int CNT_W = $clog2(FLUSH_CYC + 1);

  typedef enum logic [1:0] {
    S_RUN     = 2'd0,
    S_ST_WAIT = 2'd1,
    S_FLUSH   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             req_q;
  logic             commit;
  logic             pop_c, wena_c, req_c, rb_c;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pop_c   = 1'b0;
    wena_c  = 1'b0;
    req_c   = 1'b0;
    rb_c    = 1'b0;
    commit  = rob_hd_vld && rob_hd_done;
    if (!rdy) begin
      // Frozen: hold FSM, keep the LSU request stable, suppress every side effect.
      req_c = req_q;
    end else begin
      case (state_q)
        S_RUN: begin
          if (commit) begin
            if (rob_hd_store) begin
              req_c   = 1'b1;
              state_d = S_ST_WAIT;
            end else begin
              pop_c  = 1'b1;
              wena_c = rob_hd_wb && (rob_hd_rd != '0);
              if (rob_hd_mispred) begin
                rb_c = 1'b1;
                if (FLUSH_CYC > 1) begin
                  state_d = S_FLUSH;
                  cnt_d   = CNT_W'(FLUSH_CYC - 1);
                end
              end
            end
          end
        end
        S_ST_WAIT: begin
          req_c = 1'b1;
          if (lsu_st_ack) begin
            pop_c   = 1'b1;
            state_d = S_RUN;
          end
        end
        S_FLUSH: begin
          // ROB is being cleared, so head inputs are ignored here.
          rb_c  = 1'b1;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = S_RUN;
        end
        default: state_d = S_RUN;
      endcase
    end
  end

  always_comb begin
    reg_en     = ~rst;
    rob_pop    = 1'b0;
    lsu_st_req = 1'b0;
    reg_st     = 1'b0;
    reg_rb     = 1'b0;
    flush      = 1'b0;
    rob_wr_ena = 1'b0;
    rob_wr_rd  = '0;
    rob_wr_val = '0;
    rob_wr_idx = '0;
    if (!rst) begin
      rob_pop    = pop_c;
      lsu_st_req = req_c;
      reg_st     = id_stall;
      reg_rb     = rb_c;
      flush      = rb_c;
      rob_wr_ena = wena_c;
      rob_wr_rd  = rob_hd_rd;
      rob_wr_val = rob_hd_val;
      rob_wr_idx = rob_hd_idx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_RUN;
      cnt_q   <= '0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_c;
    end
  end

`ifdef COMMIT_CNT_EN
  logic [63:0] ccnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ccnt_q <= '0;
    end else if (pop_c && rdy) begin
      ccnt_q <= ccnt_q + 64'd1;
    end
  end

  assign commit_cnt = ccnt_q;
`endif

endmodule
